// File: rtl/md_sched.sv
// Multi-cycle multiply/divide scheduler: holds HI/LO, models mult/div latency, stalls D while busy.
// Optional stall performance counter (stall_cnt_o) is enabled by defining MD_PERF_CNT_EN.
`timescale 1ns/1ps
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        flush_i,
  input  logic        d_uses_md_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
`ifdef MD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  typedef enum logic {IDLE, BUSY} state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic             res_wr_q, res_wr_d;
  logic             done_q, done_d;
  logic             accept;

  logic        is_signed;
  logic [63:0] prod;
  logic        dvd_neg, dvs_neg;
  logic [31:0] dvd_mag, dvs_mag, dvs_safe, quo_mag, rem_mag, quo, rem;

  // Datapath: low 64 bits of a product of sign-extended operands are the signed product.
  // Division works on magnitudes so the signed overflow case never reaches a native divide.
  always_comb begin
    is_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
    if (is_signed) prod = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
    else           prod = {32'd0, rs_i} * {32'd0, rt_i};
    dvd_neg  = is_signed & rs_i[31];
    dvs_neg  = is_signed & rt_i[31];
    dvd_mag  = dvd_neg ? -rs_i : rs_i;
    dvs_mag  = dvs_neg ? -rt_i : rt_i;
    dvs_safe = (dvs_mag == 32'd0) ? 32'd1 : dvs_mag;
    quo_mag  = dvd_mag / dvs_safe;
    rem_mag  = dvd_mag % dvs_safe;
    quo      = (dvd_neg ^ dvs_neg) ? -quo_mag : quo_mag;
    rem      = dvd_neg ? -rem_mag : rem_mag;
  end

  assign accept = start_i & ~flush_i;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_wr_d = res_wr_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op_i)
            OP_MULT, OP_MULTU: begin
              res_hi_d = prod[63:32];
              res_lo_d = prod[31:0];
              res_wr_d = 1'b1;
              cnt_d    = MULT_LAST;
              state_d  = BUSY;
            end
            OP_DIV, OP_DIVU: begin
              res_hi_d = rem;
              res_lo_d = quo;
              res_wr_d = (rt_i != 32'd0);
              cnt_d    = DIV_LAST;
              state_d  = BUSY;
            end
            OP_MTHI: hi_d = rs_i;
            OP_MTLO: lo_d = rs_i;
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (res_wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
`ifndef SYNTHESIS
      if (state_q == BUSY && start_i)
        $warning("md_sched: start_i while busy is ignored");
`endif
    end
  end

  // NOTE: the pending-result registers have no reset; they are only read after a start loads them.
  always_ff @(posedge clk) begin
    res_hi_q <= res_hi_d;
    res_lo_q <= res_lo_d;
    res_wr_q <= res_wr_d;
  end

  assign busy_o  = (state_q == BUSY);
  assign stall_o = d_uses_md_i & (busy_o | (accept & (op_i <= 3'd3)));
  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

`ifdef MD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)        stall_cnt_q <= '0;
    else if (stall_o) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_md_sched.sv
// Randomized scoreboard bench for md_sched; reference model uses native integer arithmetic.
`timescale 1ns/1ps
module tb_md_sched;

  localparam int MULT_L = 5;
  localparam int DIV_L  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs_i, rt_i;
  logic        flush_i;
  logic        d_uses_md_i;
  logic        busy_o, stall_o, done_o;
  logic [31:0] hi_o, lo_o;
`ifdef MD_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  md_sched #(.MULT_CYCLES(MULT_L), .DIV_CYCLES(DIV_L)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .op_i        (op_i),
    .rs_i        (rs_i),
    .rt_i        (rt_i),
    .flush_i     (flush_i),
    .d_uses_md_i (d_uses_md_i),
    .busy_o      (busy_o),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
`ifdef MD_PERF_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          errs = 0;
  int          total = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding mult/div.
  always @(negedge clk) begin
    if (done_o) begin
      total++;
      if (sb_q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_done: done_o=1 with no pending operation (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("done_cycle", 32'(cyc), 32'(e.cyc));
        check("done_hi", hi_o, e.hi);
        check("done_lo", lo_o, e.lo);
      end
    end
  end

  // Reference model: what HI/LO become after an operation, from the architectural rules.
  task automatic ref_md(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        output logic [31:0] hi, output logic [31:0] lo);
    int sa, sb;
    longint p;
    longint unsigned pu;
    sa = int'(rs);
    sb = int'(rt);
    hi = model_hi;
    lo = model_lo;
    case (op)
      3'd0: begin p = longint'(sa) * longint'(sb); hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin pu = {32'd0, rs} * {32'd0, rt}; hi = pu[63:32]; lo = pu[31:0]; end
      3'd2: if (rt != 0) begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
      3'd3: if (rt != 0) begin lo = rs / rt; hi = rs % rt; end
      3'd4: hi = rs;
      3'd5: lo = rs;
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a start; for mult/div with commit=1 the expected completion goes to the scoreboard.
  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input bit commit);
    exp_t e;
    int lat;
    start_i = 1'b1;
    op_i    = op;
    rs_i    = rs;
    rt_i    = rt;
    flush_i = 1'b0;
    if (commit) begin
      ref_md(op, rs, rt, e.hi, e.lo);
      model_hi = e.hi;
      model_lo = e.lo;
      if (op <= 3'd3) begin
        lat   = (op >= 3'd2) ? DIV_L : MULT_L;
        e.cyc = cyc + 1 + lat;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic run_md(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input int flush_at, input logic d_use);
    int lat, busy_n, stall_n;
    lat         = (op >= 3'd2) ? DIV_L : MULT_L;
    d_uses_md_i = d_use;
    issue(op, rs, rt, 1'b1);
    busy_n  = 0;
    stall_n = 0;
    for (int k = 0; k < lat + 3; k++) begin
      @(negedge clk);
      if (busy_o)  busy_n++;
      if (stall_o) stall_n++;
      step();
      start_i = 1'b0;
      flush_i = (k + 1 == flush_at);
    end
    flush_i     = 1'b0;
    d_uses_md_i = 1'b0;
    check("busy_len", 32'(busy_n), 32'(lat));
    check("stall_len", 32'(stall_n), d_use ? 32'(lat + 1) : 32'd0);
    check("hi_after", hi_o, model_hi);
    check("lo_after", lo_o, model_lo);
  endtask

  task automatic do_single(input logic [2:0] op, input logic [31:0] rs);
    issue(op, rs, $urandom, 1'b1);
    step();
    check("single_busy", {31'd0, busy_o}, 32'd0);
    check("single_hi", hi_o, model_hi);
    check("single_lo", lo_o, model_lo);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] rs, rt;
    int          fl;

    reset = 1'b1; start_i = 1'b0; op_i = '0; rs_i = '0; rt_i = '0;
    flush_i = 1'b0; d_uses_md_i = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_hi", hi_o, 32'd0);
    check("rst_lo", lo_o, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);

    // mult -2 * 3
    run_md(3'd0, 32'hFFFFFFFE, 32'd3, -1, 1'b1);
    check("mult_hi_const", hi_o, 32'hFFFFFFFF);
    check("mult_lo_const", lo_o, 32'hFFFFFFFA);

    // div / divu -7, 2
    run_md(3'd2, 32'hFFFFFFF9, 32'd2, -1, 1'b1);
    check("div_lo_const", lo_o, 32'hFFFFFFFD);
    check("div_hi_const", hi_o, 32'hFFFFFFFF);
    run_md(3'd3, 32'hFFFFFFF9, 32'd2, -1, 1'b1);
    check("divu_lo_const", lo_o, 32'h7FFFFFFC);
    check("divu_hi_const", hi_o, 32'h00000001);

    // mthi/mtlo back to back
    do_single(3'd4, 32'h12345678);
    check("mthi_const", hi_o, 32'h12345678);
    do_single(3'd5, 32'hCAFEBABE);
    check("mtlo_const", lo_o, 32'hCAFEBABE);
    start_i = 1'b0;

    // divide by zero keeps HI/LO
    do_single(3'd4, 32'h11);
    do_single(3'd5, 32'h22);
    start_i = 1'b0;
    run_md(3'd3, 32'h1234, 32'd0, -1, 1'b1);
    check("div0_hi", hi_o, 32'h11);
    check("div0_lo", lo_o, 32'h22);

    // start with flush in the same cycle is dropped
    d_uses_md_i = 1'b1;
    issue(3'd0, 32'h7, 32'h9, 1'b0);
    flush_i = 1'b1;
    @(negedge clk);
    check("flush_start_stall", {31'd0, stall_o}, 32'd0);
    step();
    start_i = 1'b0; flush_i = 1'b0; d_uses_md_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("flush_start_busy", {31'd0, busy_o}, 32'd0);
      step();
    end
    check("flush_start_hi", hi_o, model_hi);
    check("flush_start_lo", lo_o, model_lo);

    // flush during busy does not cancel
    run_md(3'd2, 32'd100, 32'hFFFFFFF9, 3, 1'b1);

    // reset mid-operation discards the result
    issue(3'd2, 32'd1000, 32'd7, 1'b0);
    step();
    start_i = 1'b0;
    step(); step(); step();
    check("pre_reset_busy", {31'd0, busy_o}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_hi = '0;
    model_lo = '0;
    check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    check("mid_rst_hi", hi_o, 32'd0);
    check("mid_rst_lo", lo_o, 32'd0);
    for (int k = 0; k < DIV_L; k++) begin
      check("mid_rst_no_done", {31'd0, done_o}, 32'd0);
      step();
    end
    run_md(3'd0, 32'h00010001, 32'h00010001, -1, 1'b1);

    // randomized mix
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      rs = $urandom;
      rt = $urandom;
      case ($urandom_range(0, 5))
        0: rt = 32'd0;
        1: rt = 32'($urandom_range(1, 9));
        2: rs = 32'($urandom_range(0, 50));
        default: ;
      endcase
      if (op == 3'd2 && rs == 32'h80000000 && rt == 32'hFFFFFFFF) rt = 32'd1;
      if (op <= 3'd3) begin
        fl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : -1;
        run_md(op, rs, rt, fl, 1'($urandom_range(0, 1)));
      end else begin
        do_single(op, rs);
        start_i = 1'b0;
      end
    end

    step(); step();
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end

endmodule
